pdm_cic_decim: RTL and testbench

Parametrised multi-channel PDM-to-PCM decimator. It is the successor to the fixed 4-stage, 24-bit mono CIC filter.
- One shared PDM data line carries CHANNELS interleaved channels. Each channel is sampled on its own strobe from the audio clock generator.
- Runs the CIC integrators at PDM rate and owns its decimation counter. The comb section is time-multiplexed through one subtractor.
- Emits saturated OUT_W-bit PCM with a valid pulse, per-channel clip flags and a sticky overrun flag.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/cic_integrator_chain.sv | 45 ++++
 rtl/pdm_cic_decim.sv | 164 ++++++++++++++++
 tb/tb_pdm_cic_decim.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared helpers and types for the PDM/CIC audio front end.
// Holds the PDM sample mapping, a constant clog2 and the parameter width check.
package audio_pkg;

    localparam int PDM_POS = 1;
    localparam int PDM_NEG = -1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        SAT  = 2'd2
    } cic_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Accumulator must hold the full CIC gain plus sign, and the shift must leave bits.
    function automatic bit widths_ok(input int w, input int order, input int decim, input int shift);
        return (w >= order * clog2(decim) + 2) && (shift < w);
    endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// One channel of CIC integrators running at the PDM sample rate.
// out is the value of the last stage as it will be after this cycle's update.
module cic_integrator_chain
    import audio_pkg::*;
#(
    parameter int W     = 32,
    parameter int ORDER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] out
);

    logic [W-1:0] acc [ORDER];
    logic [W-1:0] step;

    always_comb begin
        step = din ? W'(PDM_POS) : W'(PDM_NEG);
    end

    // Every stage reads the old value of its predecessor, giving one cycle of skew per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                acc[k] <= '0;
            end
        end else if (en) begin
            acc[0] <= acc[0] + step;
            for (int k = 1; k < ORDER; k++) begin
                acc[k] <= acc[k] + acc[k-1];
            end
        end
    end

    generate
        if (ORDER == 1) begin : g_single
            assign out = en ? acc[0] + step : acc[0];
        end else begin : g_multi
            assign out = en ? acc[ORDER-1] + acc[ORDER-2] : acc[ORDER-1];
        end
    endgenerate

endmodule

// File: rtl/pdm_cic_decim.sv
// Multi-channel PDM-to-PCM CIC decimator: per-channel integrators, one shared
// time-multiplexed comb subtractor, then shift and saturation to OUT_W bits.
module pdm_cic_decim
    import audio_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int ORDER     = 4,
    parameter int DECIM     = 64,
    parameter int W         = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 10,
    parameter int DC_REMOVE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    input  logic [CHANNELS-1:0]       stb_sample,
    output logic [CHANNELS*OUT_W-1:0] pcm_data,
    output logic                      pcm_valid,
    output logic [CHANNELS-1:0]       pcm_clip,
    output logic                      overrun
);

    localparam int S     = ORDER + DC_REMOVE;
    localparam int CNT_W = (clog2(DECIM) < 1) ? 1 : clog2(DECIM);
    localparam int CH_W  = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS);
    localparam int ST_W  = (clog2(S) < 1) ? 1 : clog2(S);

    localparam logic signed [W-1:0] PCM_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] PCM_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    generate
        if (!widths_ok(W, ORDER, DECIM, SHIFT)) begin : g_width_check
            $error("pdm_cic_decim: W too small for ORDER/DECIM, or SHIFT >= W");
        end
    endgenerate

    logic [W-1:0]        integ_out [CHANNELS];
    logic [CNT_W-1:0]    dec_cnt;
    logic                dec_event;

    cic_state_t          state;
    logic [CH_W-1:0]     ch;
    logic [ST_W-1:0]     st;
    logic [W-1:0]        v;
    logic [W-1:0]        snap [CHANNELS];
    logic [W-1:0]        dly [CHANNELS][S];
    logic signed [W-1:0] res [CHANNELS];

    logic [W-1:0]        comb_in;
    logic [W-1:0]        comb_y;
    logic signed [W-1:0] shifted [CHANNELS];
    logic [OUT_W-1:0]    sat_data [CHANNELS];
    logic [CHANNELS-1:0] sat_clip;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            cic_integrator_chain #(
                .W     (W),
                .ORDER (ORDER)
            ) u_integ (
                .clk (clk),
                .rst (rst),
                .en  (stb_sample[c]),
                .din (din),
                .out (integ_out[c])
            );
        end
    endgenerate

    assign dec_event = stb_sample[0] && (dec_cnt == CNT_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (stb_sample[0]) begin
            dec_cnt <= dec_event ? '0 : dec_cnt + 1'b1;
        end
    end

    // The first stage of each channel pulls its snapshot; later stages chain through v.
    always_comb begin
        comb_in = (st == '0) ? snap[ch] : v;
        comb_y  = comb_in - dly[ch][st];
    end

    always_comb begin
        sat_clip = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            shifted[c]  = res[c] >>> SHIFT;
            sat_data[c] = shifted[c][OUT_W-1:0];
            if (shifted[c] > PCM_MAX) begin
                sat_data[c] = PCM_MAX[OUT_W-1:0];
                sat_clip[c] = 1'b1;
            end else if (shifted[c] < PCM_MIN) begin
                sat_data[c] = PCM_MIN[OUT_W-1:0];
                sat_clip[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            st        <= '0;
            v         <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            pcm_clip  <= '0;
            overrun   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                snap[c] <= '0;
                res[c]  <= '0;
                for (int k = 0; k < S; k++) begin
                    dly[c][k] <= '0;
                end
            end
        end else begin
            pcm_valid <= 1'b0;
            // Events landing while the comb is busy are dropped, leaving snapshots intact.
            if (dec_event && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dec_event) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            snap[c] <= integ_out[c];
                        end
                        ch    <= '0;
                        st    <= '0;
                        state <= COMB;
                    end
                end
                COMB: begin
                    dly[ch][st] <= comb_in;
                    v           <= comb_y;
                    if (st == ST_W'(S - 1)) begin
                        res[ch] <= comb_y;
                        st      <= '0;
                        if (ch == CH_W'(CHANNELS - 1)) begin
                            state <= SAT;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        st <= st + 1'b1;
                    end
                end
                SAT: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        pcm_data[c*OUT_W +: OUT_W] <= sat_data[c];
                    end
                    pcm_clip  <= sat_clip;
                    pcm_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Self-checking bench for pdm_cic_decim: four parameterisations share clock and reset,
// settled PCM values come from a table and are scoreboarded per output pulse.
module tb_pdm_cic_decim;

    typedef struct {
        logic        din0;
        logic        din1;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [1:0]  aclip;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [1:0]  bclip;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    typedef struct packed {
        logic        chk;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  clip;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [1:0]  stb = 2'b00;
    logic        din_d = 1'b0;
    logic [3:0]  stb_d = 4'b0000;

    logic [31:0] data_x [3];
    logic [2:0]  valid_x;
    logic [1:0]  clip_x [3];
    logic [2:0]  ovr_x;
    logic [63:0] data_d;
    logic        valid_d;
    logic [3:0]  clip_d;
    logic        ovr_d;

    int   n_vec = 0;
    int   n_mis = 0;
    int   pulses [3];
    int   pairs = 0;
    bit   c_seen_nonzero = 0;
    exp_t exp_a [$];
    exp_t exp_b [$];
    exp_t exp_c [$];
    vec_t vecs [3];

    always #5 clk = ~clk;

    // a: SHIFT=10 no DC removal, b: SHIFT=8 (saturates), c: DC removal on
    pdm_cic_decim #(.CHANNELS(2), .ORDER(4), .DECIM(64), .W(32), .OUT_W(16), .SHIFT(10), .DC_REMOVE(0)) u_a (
        .clk(clk), .rst(rst), .din(din), .stb_sample(stb),
        .pcm_data(data_x[0]), .pcm_valid(valid_x[0]), .pcm_clip(clip_x[0]), .overrun(ovr_x[0]));
    pdm_cic_decim #(.CHANNELS(2), .ORDER(4), .DECIM(64), .W(32), .OUT_W(16), .SHIFT(8), .DC_REMOVE(0)) u_b (
        .clk(clk), .rst(rst), .din(din), .stb_sample(stb),
        .pcm_data(data_x[1]), .pcm_valid(valid_x[1]), .pcm_clip(clip_x[1]), .overrun(ovr_x[1]));
    pdm_cic_decim #(.CHANNELS(2), .ORDER(4), .DECIM(64), .W(32), .OUT_W(16), .SHIFT(10), .DC_REMOVE(1)) u_c (
        .clk(clk), .rst(rst), .din(din), .stb_sample(stb),
        .pcm_data(data_x[2]), .pcm_valid(valid_x[2]), .pcm_clip(clip_x[2]), .overrun(ovr_x[2]));
    pdm_cic_decim #(.CHANNELS(4), .ORDER(6), .DECIM(2), .W(32), .OUT_W(16), .SHIFT(10), .DC_REMOVE(1)) u_d (
        .clk(clk), .rst(rst), .din(din_d), .stb_sample(stb_d),
        .pcm_data(data_d), .pcm_valid(valid_d), .pcm_clip(clip_d), .overrun(ovr_d));

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard consumer: every pcm_valid pops one expected record for that DUT.
    initial begin
        exp_t e;
        bit   got;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (valid_x[i]) begin
                    pulses[i]++;
                    got = 0;
                    e   = '0;
                    case (i)
                        0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); got = 1; end
                        1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); got = 1; end
                        default: if (exp_c.size() > 0) begin e = exp_c.pop_front(); got = 1; end
                    endcase
                    if (i == 2 && pulses[2] < 7 && data_x[2] != 32'd0) c_seen_nonzero = 1;
                    if (!got) begin
                        n_vec++;
                        n_mis++;
                        $display("[TB] FAIL unexpected_valid dut%0d: got pcm_valid=1, expected 0", i);
                    end else if (e.chk) begin
                        checkOutput($sformatf("dut%0d_p%0d_ch0", i, pulses[i]), {16'd0, data_x[i][15:0]}, {16'd0, e.d0});
                        checkOutput($sformatf("dut%0d_p%0d_ch1", i, pulses[i]), {16'd0, data_x[i][31:16]}, {16'd0, e.d1});
                        checkOutput($sformatf("dut%0d_p%0d_clip", i, pulses[i]), {30'd0, clip_x[i]}, {30'd0, e.clip});
                    end
                end
            end
        end
    end

    task automatic doReset();
        rst   = 1'b1;
        stb   = 2'b00;
        stb_d = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst   = 1'b0;
        pairs = 0;
    endtask

    // One ch0 strobe then one ch1 strobe, 20 clocks apart; entered and left at posedge+1.
    task automatic strobePair(input logic d0, input logic d1);
        stb = 2'b01; din = d0;
        @(posedge clk); #1;
        stb = 2'b00;
        repeat (19) @(posedge clk);
        #1;
        stb = 2'b10; din = d1;
        @(posedge clk); #1;
        stb = 2'b00;
        repeat (19) @(posedge clk);
        #1;
        pairs++;
    endtask

    task automatic applyStimulus(input vec_t v, input bit do_reset, input int np);
        if (do_reset) doReset();
        exp_a.delete(); exp_b.delete(); exp_c.delete();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        c_seen_nonzero = 0;
        for (int p = 1; p <= np; p++) begin
            exp_a.push_back('{p >= 6, v.a0, v.a1, v.aclip});
            exp_b.push_back('{p >= 6, v.b0, v.b1, v.bclip});
            exp_c.push_back('{p >= 7, v.c0, v.c1, 2'b00});
        end
        while (!(pulses[0] >= np && pulses[1] >= np && pulses[2] >= np) && pairs < np * 64 + 8) begin
            strobePair(v.din0, v.din1);
        end
        if (pulses[0] < np || pulses[1] < np || pulses[2] < np) begin
            n_vec++;
            n_mis++;
            $display("[TB] FAIL pulse_timeout: got %0d/%0d/%0d pulses, expected %0d", pulses[0], pulses[1], pulses[2], np);
        end
        exp_a.delete(); exp_b.delete(); exp_c.delete();
    endtask

    initial begin
        int first_valid;
        int nvalid;

        vecs[0] = '{1'b1, 1'b1, 16'h4000, 16'h4000, 2'b00, 16'h7FFF, 16'h7FFF, 2'b11, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'hC000, 16'hC000, 2'b00, 16'h8000, 16'h8000, 2'b11, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h4000, 16'hC000, 2'b00, 16'h7FFF, 16'h8000, 2'b11, 16'h0000, 16'h0000};

        doReset();
        checkOutput("reset_pcm_data", data_x[0], 32'd0);
        checkOutput("reset_pcm_valid", {29'd0, valid_x}, 32'd0);
        checkOutput("reset_pcm_clip", {30'd0, clip_x[0]}, 32'd0);
        checkOutput("reset_overrun", {29'd0, ovr_x}, 32'd0);

        for (int r = 0; r < 3; r++) begin
            applyStimulus(vecs[r], 1'b1, 7);
            if (r == 0) begin
                checkOutput("dc_transient_nonzero", {31'd0, c_seen_nonzero}, 32'd1);

                // Run up to the next decimation event and reset while the comb is working.
                while (pairs % 64 != 63) strobePair(1'b1, 1'b1);
                stb = 2'b01; din = 1'b1;
                @(posedge clk); #1;
                stb = 2'b00;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checkOutput("midcomb_rst_data_a", data_x[0], 32'd0);
                checkOutput("midcomb_rst_data_b", data_x[1], 32'd0);
                checkOutput("midcomb_rst_clip_b", {30'd0, clip_x[1]}, 32'd0);
                checkOutput("midcomb_rst_valid", {29'd0, valid_x}, 32'd0);
                checkOutput("midcomb_rst_overrun", {29'd0, ovr_x}, 32'd0);
                repeat (40) @(posedge clk);
                #1;
                pairs = 0;
                applyStimulus(vecs[0], 1'b0, 6);
            end
        end

        // Overrun: strobe ch0 every cycle on a DECIM=2 instance whose comb takes 28 cycles.
        doReset();
        din_d = 1'b1;
        stb_d = 4'b0001;
        first_valid = -1;
        nvalid = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("overrun_before_2nd_event", {31'd0, ovr_d}, 32'd0);
            if (k == 5) checkOutput("overrun_after_2nd_event", {31'd0, ovr_d}, 32'd1);
            if (valid_d) begin
                nvalid++;
                if (first_valid < 0) first_valid = k;
            end
            @(posedge clk); #1;
        end
        checkOutput("overrun_first_valid_cycle", first_valid, 32'd32);
        checkOutput("overrun_valid_count", nvalid, 32'd3);
        checkOutput("overrun_sticky", {31'd0, ovr_d}, 32'd1);
        stb_d = 4'b0000;
        doReset();
        checkOutput("overrun_cleared_by_rst", {31'd0, ovr_d}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
